// File: rtl/cache_pkg.sv
// Shared types and geometry for the L1 line-transfer engine.
// Line = 64 B split into eight 8 B beats; 64 sets.
package cache_pkg;

  localparam int LINE_BYTES = 64;
  localparam int BEAT_BYTES = 8;
  localparam int BEATS      = 8;
  localparam int SET_W      = 6;
  localparam int OFF_W      = 6;
  localparam int BEAT_W     = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_REFILL  = 3'd2,
    S_WB_DATA = 3'd3,
    S_WB_ACK  = 3'd4
  } xfer_state_t;

  // RAM byte address of one beat inside a set: {52'b0, set, beat, 3'b0}
  function automatic logic [63:0] ram_beat_addr(input logic [SET_W-1:0] set,
                                                input logic [BEAT_W-1:0] beat);
    return {52'd0, set, beat, 3'd0};
  endfunction

endpackage

// File: rtl/cache_line_xfer.sv
// Whole-line refill (memory -> cache RAM) and writeback (cache RAM -> memory)
// engine, driven by the cache controller through one valid/ready request port.
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int BEATS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wb,
  input  logic [63:0] req_mem_addr,
  input  logic [5:0]  req_set,
  output logic        done,
  output logic        ram_wen,
  output logic [3:0]  ram_write_mask,
  output logic [63:0] ram_w_addr,
  output logic [63:0] ram_r_addr,
  output logic [63:0] ram_data_in,
  input  logic [63:0] ram_data_out,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_we,
  output logic [63:0] mem_cmd_addr,
  input  logic        mem_rd_valid,
  output logic        mem_rd_ready,
  input  logic [63:0] mem_rd_data,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [63:0] mem_wr_data,
  output logic        mem_wr_last,
  input  logic        mem_wr_ack
);

  xfer_state_t         r_state;
  xfer_state_t         w_next;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_wb;
  logic [63-OFF_W:0]   r_line;
  logic [SET_W-1:0]    r_set;
  logic                r_done;
  logic                w_accept;
  logic                w_rd_beat;
  logic                w_wr_beat;
  logic                w_last_beat;
  logic                w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^req_mem_addr[OFF_W-1:0];
  assign w_last_beat       = (r_beat == BEAT_W'(BEATS - 1));
  assign w_accept          = (r_state == S_IDLE) && req_valid;
  assign w_rd_beat         = (r_state == S_REFILL) && mem_rd_valid;
  assign w_wr_beat         = (r_state == S_WB_DATA) && mem_wr_ready;
  assign done              = r_done;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // request latch, beat counter (wraps 7->0 at line end) and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_wb   <= 1'b0;
      r_line <= '0;
      r_set  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (w_rd_beat && w_last_beat) || ((r_state == S_WB_ACK) && mem_wr_ack);
      if (w_accept) begin
        r_wb   <= req_wb;
        r_line <= req_mem_addr[63:OFF_W];
        r_set  <= req_set;
        r_beat <= '0;
      end else if (w_rd_beat || w_wr_beat) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req_valid) w_next = S_CMD; else w_next = S_IDLE;
      S_CMD: begin
        if (mem_cmd_ready) w_next = r_wb ? S_WB_DATA : S_REFILL;
        else               w_next = S_CMD;
      end
      S_REFILL:  if (mem_rd_valid && w_last_beat) w_next = S_IDLE;   else w_next = S_REFILL;
      S_WB_DATA: if (mem_wr_ready && w_last_beat) w_next = S_WB_ACK; else w_next = S_WB_DATA;
      S_WB_ACK:  if (mem_wr_ack) w_next = S_IDLE; else w_next = S_WB_ACK;
      default:   w_next = S_IDLE;
    endcase
  end

  // output decode; everything idles at zero outside its own state
  always_comb begin
    req_ready      = 1'b0;
    mem_cmd_valid  = 1'b0;
    mem_cmd_we     = 1'b0;
    mem_cmd_addr   = '0;
    mem_rd_ready   = 1'b0;
    ram_wen        = 1'b0;
    ram_write_mask = '0;
    ram_w_addr     = '0;
    ram_r_addr     = '0;
    ram_data_in    = '0;
    mem_wr_valid   = 1'b0;
    mem_wr_data    = '0;
    mem_wr_last    = 1'b0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = r_wb;
        mem_cmd_addr  = {r_line, {OFF_W{1'b0}}};
      end
      S_REFILL: begin
        mem_rd_ready = 1'b1;
        ram_w_addr   = ram_beat_addr(r_set, r_beat);
        if (mem_rd_valid) begin
          ram_wen        = 1'b1;
          ram_write_mask = 4'd8;
          ram_data_in    = mem_rd_data;
        end else begin
          ram_wen        = 1'b0;
          ram_write_mask = 4'd0;
          ram_data_in    = 64'd0;
        end
      end
      S_WB_DATA: begin
        ram_r_addr   = ram_beat_addr(r_set, r_beat);
        mem_wr_valid = 1'b1;
        mem_wr_data  = ram_data_out;
        mem_wr_last  = w_last_beat;
      end
      S_WB_ACK: req_ready = 1'b0;
      default:  req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_line_xfer.sv
// Self-checking bench for cache_line_xfer: table of transfers plus hand-written
// reset and back-to-back sequences, RAM/memory traffic checked through scoreboards.
module tb_cache_line_xfer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wb;
  logic [63:0] req_mem_addr;
  logic [5:0]  req_set;
  logic        done;
  logic        ram_wen;
  logic [3:0]  ram_write_mask;
  logic [63:0] ram_w_addr;
  logic [63:0] ram_r_addr;
  logic [63:0] ram_data_in;
  logic [63:0] ram_data_out;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_we;
  logic [63:0] mem_cmd_addr;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [63:0] mem_rd_data;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [63:0] mem_wr_data;
  logic        mem_wr_last;
  logic        mem_wr_ack;

  cache_line_xfer #(.BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
    .req_mem_addr(req_mem_addr), .req_set(req_set), .done(done),
    .ram_wen(ram_wen), .ram_write_mask(ram_write_mask), .ram_w_addr(ram_w_addr),
    .ram_r_addr(ram_r_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
    .mem_rd_data(mem_rd_data), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last), .mem_wr_ack(mem_wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache RAM model: combinational read, write on ram_wen
  logic [63:0] tb_ram [0:511];
  always @(posedge clk) if (ram_wen) tb_ram[ram_w_addr[11:3]] <= ram_data_in;
  assign ram_data_out = tb_ram[ram_r_addr[11:3]];

  typedef struct { logic [63:0] addr; logic [63:0] data; } rexp_t;
  typedef struct { logic [63:0] data; logic last; } wexp_t;
  typedef struct {
    logic wb; logic [5:0] set; logic [63:0] addr; logic [63:0] exp_cmd; logic [63:0] exp_base;
    int cmd_stall; int gap; int stall_beat; int stall_cyc; int ack_dly; bit plain;
  } vec_t;

  rexp_t       rq[$];
  wexp_t       wq[$];
  rexp_t       r_e;
  wexp_t       w_e;
  logic [63:0] shadow [0:511];
  vec_t        vecs [6];
  int          total = 0;
  int          bad = 0;

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk64(nm, 64'(act), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard consumers: RAM writes and memory write-data handshakes
  always @(negedge clk) begin
    if (ram_wen) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ram_write: got addr=%h want none", ram_w_addr);
      end else begin
        r_e = rq.pop_front();
        chk64("ram_w_addr", ram_w_addr, r_e.addr);
        chk64("ram_data_in", ram_data_in, r_e.data);
        chk64("ram_mask", 64'(ram_write_mask), 64'd8);
      end
    end
    if (mem_wr_valid && mem_wr_ready) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wr_beat: got data=%h want none", mem_wr_data);
      end else begin
        w_e = wq.pop_front();
        chk64("mem_wr_data", mem_wr_data, w_e.data);
        chk1("mem_wr_last", mem_wr_last, w_e.last);
      end
    end
  end

  task automatic req_phase(input logic wb, input logic [5:0] set, input logic [63:0] addr);
    req_valid = 1'b1; req_wb = wb; req_set = set; req_mem_addr = addr;
    @(negedge clk);
    chk1("req_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic cmd_phase(input logic [63:0] exp_addr, input logic exp_we, input int stall);
    mem_cmd_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      mem_rd_valid = 1'b1; mem_wr_ack = 1'b1; mem_wr_ready = 1'b1;
      @(negedge clk);
      chk1("cmd_valid_stall", mem_cmd_valid, 1'b1);
      chk64("cmd_addr_stall", mem_cmd_addr, exp_addr);
      chk1("cmd_we_stall", mem_cmd_we, exp_we);
      chk1("cmd_no_ram_wen", ram_wen, 1'b0);
      chk1("cmd_no_wr_valid", mem_wr_valid, 1'b0);
      chk1("cmd_no_rd_ready", mem_rd_ready, 1'b0);
      tick();
    end
    mem_rd_valid = 1'b0; mem_wr_ack = 1'b0; mem_wr_ready = 1'b0;
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    chk1("cmd_valid", mem_cmd_valid, 1'b1);
    chk64("cmd_addr", mem_cmd_addr, exp_addr);
    chk1("cmd_we", mem_cmd_we, exp_we);
    chk1("busy_not_ready", req_ready, 1'b0);
    chk1("done_low_cmd", done, 1'b0);
    tick();
    mem_cmd_ready = 1'b0;
  endtask

  task automatic refill_beats(input logic [5:0] set, input logic [63:0] base,
                              input int gap, input int n, input bit plain);
    logic [63:0] d;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk1("gap_no_wen", ram_wen, 1'b0);
        chk1("gap_rd_ready", mem_rd_ready, 1'b1);
        chk64("gap_addr_frozen", ram_w_addr, base + 64'(k * 8));
        tick();
      end
      if (plain) d = 64'h1111_1111_1111_1111 * 64'(k + 1);
      else       d = {$urandom, $urandom};
      rq.push_back('{addr: base + 64'(k * 8), data: d});
      shadow[{set, 3'(k)}] = d;
      mem_rd_valid = 1'b1; mem_rd_data = d;
      @(negedge clk);
      chk1("refill_done_low", done, 1'b0);
      chk1("refill_not_ready", req_ready, 1'b0);
      tick();
      mem_rd_valid = 1'b0;
    end
    if (n == 8) begin
      @(negedge clk);
      chk1("refill_done_pulse", done, 1'b1);
      chk1("refill_idle_ready", req_ready, 1'b1);
      tick();
    end
  endtask

  task automatic wb_beats(input logic [5:0] set, input logic [63:0] base,
                          input int stall_beat, input int stall_cyc);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) begin
      d = shadow[{set, 3'(b)}];
      wq.push_back('{data: d, last: (b == 7)});
      mem_wr_ready = 1'b0;
      if (b == stall_beat) begin
        for (int s = 0; s < stall_cyc; s++) begin
          mem_wr_ack = 1'b1;
          @(negedge clk);
          chk1("stall_wr_valid", mem_wr_valid, 1'b1);
          chk64("stall_wr_data", mem_wr_data, d);
          chk1("stall_wr_last", mem_wr_last, (b == 7));
          chk64("stall_r_addr", ram_r_addr, base + 64'(b * 8));
          tick();
        end
      end
      mem_wr_ack = 1'b0;
      mem_wr_ready = 1'b1;
      @(negedge clk);
      chk1("wb_done_low", done, 1'b0);
      tick();
    end
    mem_wr_ready = 1'b0;
  endtask

  task automatic ack_phase(input int dly);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk1("ack_wait_no_wr", mem_wr_valid, 1'b0);
      chk1("ack_wait_done_low", done, 1'b0);
      chk1("ack_wait_not_ready", req_ready, 1'b0);
      tick();
    end
    mem_wr_ack = 1'b1;
    @(negedge clk);
    chk1("ack_cycle_done_low", done, 1'b0);
    tick();
    mem_wr_ack = 1'b0;
    @(negedge clk);
    chk1("wb_done_pulse", done, 1'b1);
    chk1("wb_idle_ready", req_ready, 1'b1);
    tick();
  endtask

  task automatic do_xfer(input vec_t v);
    req_phase(v.wb, v.set, v.addr);
    cmd_phase(v.exp_cmd, v.wb, v.cmd_stall);
    if (!v.wb) begin
      refill_beats(v.set, v.exp_base, v.gap, 8, v.plain);
    end else begin
      wb_beats(v.set, v.exp_base, v.stall_beat, v.stall_cyc);
      ack_phase(v.ack_dly);
    end
    @(negedge clk);
    chk1("done_one_cycle", done, 1'b0);
    chk64("sb_ram_empty", 64'(rq.size()), 64'd0);
    chk64("sb_wr_empty", 64'(wq.size()), 64'd0);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_ram_wen"}, ram_wen, 1'b0);
    chk64({tag, "_mask"}, 64'(ram_write_mask), 64'd0);
    chk64({tag, "_w_addr"}, ram_w_addr, 64'd0);
    chk64({tag, "_data_in"}, ram_data_in, 64'd0);
    chk1({tag, "_cmd_valid"}, mem_cmd_valid, 1'b0);
    chk64({tag, "_cmd_addr"}, mem_cmd_addr, 64'd0);
    chk1({tag, "_rd_ready"}, mem_rd_ready, 1'b0);
    chk1({tag, "_wr_valid"}, mem_wr_valid, 1'b0);
    chk1({tag, "_wr_last"}, mem_wr_last, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_mem_addr = 64'd0; req_set = 6'd0;
    mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 64'hDEAD_BEEF_0000_0001;
    mem_wr_ready = 1'b0; mem_wr_ack = 1'b0;

    //          wb    set    addr                    exp_cmd                 exp_base  cs gap sb sc ack plain
    vecs[0] = '{1'b0, 6'd5,  64'h0000_0000_8000_0047, 64'h0000_0000_8000_0040, 64'h140, 0, 0, -1, 0, 0, 1'b1};
    vecs[1] = '{1'b0, 6'd12, 64'h1234_5678_9ABC_DEFF, 64'h1234_5678_9ABC_DEC0, 64'h300, 0, 2, -1, 0, 0, 1'b0};
    vecs[2] = '{1'b0, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 64'hFC0, 0, 0, -1, 0, 0, 1'b0};
    vecs[3] = '{1'b1, 6'd63, 64'h0000_0000_4000_0010, 64'h0000_0000_4000_0000, 64'hFC0, 0, 0,  2, 3, 5, 1'b0};
    vecs[4] = '{1'b0, 6'd0,  64'h0000_0000_0000_0040, 64'h0000_0000_0000_0040, 64'h000, 4, 0, -1, 0, 0, 1'b0};
    vecs[5] = '{1'b1, 6'd5,  64'h0000_0000_8000_0047, 64'h0000_0000_8000_0040, 64'h140, 4, 0,  7, 1, 0, 1'b0};

    #3;
    chk_reset_outputs("rst");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

    // reset in the middle of a refill, after beat 3
    req_phase(1'b0, 6'd33, 64'h0000_0000_0000_0840);
    cmd_phase(64'h0000_0000_0000_0840, 1'b0, 0);
    refill_beats(6'd33, 64'h840, 0, 4, 1'b0);
    mem_rd_valid = 1'b1; mem_rd_data = 64'hCAFE_F00D_1234_5678;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1; mem_rd_valid = 1'b0;
    tick();
    do_xfer('{1'b0, 6'd33, 64'h0000_0000_0000_0840, 64'h0000_0000_0000_0840, 64'h840,
              0, 1, -1, 0, 0, 1'b0});

    // back-to-back: request held, writeback accepted in the refill's done cycle
    req_valid = 1'b1; req_wb = 1'b0; req_set = 6'd20; req_mem_addr = 64'h0000_1000_0000_0080;
    @(negedge clk);
    chk1("b2b_first_ready", req_ready, 1'b1);
    tick();
    req_wb = 1'b1; req_mem_addr = 64'h0000_2000_0000_00C5;
    cmd_phase(64'h0000_1000_0000_0080, 1'b0, 0);
    refill_beats(6'd20, 64'h500, 0, 8, 1'b0);
    req_valid = 1'b0;
    cmd_phase(64'h0000_2000_0000_00C0, 1'b1, 0);
    wb_beats(6'd20, 64'h500, -1, 0);
    ack_phase(2);
    @(negedge clk);
    chk1("b2b_done_one_cycle", done, 1'b0);
    chk64("b2b_sb_ram_empty", 64'(rq.size()), 64'd0);
    chk64("b2b_sb_wr_empty", 64'(wq.size()), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
